// File: rtl/fetch_stage.sv
// IF stage: owns the program counter, drives INST_ADDR and loads the IF/ID register.
// Optional performance counters (FETCH_CNT, BUBBLE_CNT) exist when IF_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        NRST,
  output logic [31:0] INST_ADDR,
  input  logic [31:0] INST,
  input  logic        INST_RDY,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] ID_INST,
  output logic [31:0] ID_PC4,
  output logic        ID_VALID
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] FETCH_CNT,
  output logic [31:0] BUBBLE_CNT
`endif
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc4;
  logic        load_inst;
  logic        load_bubble;

  assign pc4       = pc_q + 32'd4;
  assign INST_ADDR = pc_q;

  // Priority: redirect, flush, stall, wait state, normal fetch.
  always_comb begin
    pc_d        = pc_q;
    load_inst   = 1'b0;
    load_bubble = 1'b0;
    if (REDIRECT) begin
      pc_d        = {REDIRECT_PC[31:2], 2'b00};
      load_bubble = 1'b1;
    end else if (FLUSH) begin
      load_bubble = 1'b1;
      if (INST_RDY && !STALL) pc_d = pc4;
    end else if (STALL) begin
      pc_d = pc_q;
    end else if (!INST_RDY) begin
      load_bubble = 1'b1;
    end else begin
      load_inst = 1'b1;
      pc_d      = pc4;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      pc_q     <= RESET_PC;
      ID_INST  <= NOP_INST;
      ID_PC4   <= '0;
      ID_VALID <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (load_bubble) begin
        ID_INST  <= NOP_INST;
        ID_PC4   <= '0;
        ID_VALID <= 1'b0;
      end else if (load_inst) begin
        ID_INST  <= INST;
        ID_PC4   <= pc4;
        ID_VALID <= 1'b1;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      FETCH_CNT  <= '0;
      BUBBLE_CNT <= '0;
    end else begin
      if (load_inst)   FETCH_CNT  <= FETCH_CNT + 32'd1;
      if (load_bubble) BUBBLE_CNT <= BUBBLE_CNT + 32'd1;
    end
  end
`endif

endmodule
